// File: rtl/normal_op_loader_pkg.sv
// Shared constants and FSM encoding for the normal-op duty/phase loader.
package normal_op_loader_pkg;
   localparam int WIDTH     = 13;
   localparam int TRANS_NUM = 249;
   localparam int RD_LAT    = 2;
   localparam int ADDR_W    = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_DRAIN,
      ST_COMMIT
   } state_t;
endpackage

// File: rtl/normal_op_loader_if.sv
// Update/BRAM/output bundle between the sync stage, duty/phase BRAM and silent stage.
interface normal_op_loader_if #(
   parameter int WIDTH = normal_op_loader_pkg::WIDTH,
   parameter int DEPTH = normal_op_loader_pkg::TRANS_NUM
);
   import normal_op_loader_pkg::*;

   logic                          i_update;
   logic [DEPTH-1:0][WIDTH-1:0]   i_cycle;
   logic [ADDR_W-1:0]             o_bram_addr;
   logic [31:0]                   i_bram_dout;
   logic [DEPTH-1:0][WIDTH-1:0]   o_duty;
   logic [DEPTH-1:0][WIDTH-1:0]   o_phase;
   logic                          o_busy;
   logic                          o_out_valid;
   logic                          o_overrun;

   modport master (
      output i_update, i_cycle, i_bram_dout,
      input  o_bram_addr, o_duty, o_phase, o_busy, o_out_valid, o_overrun
   );

   modport slave (
      input  i_update, i_cycle, i_bram_dout,
      output o_bram_addr, o_duty, o_phase, o_busy, o_out_valid, o_overrun
   );
endinterface

// File: rtl/normal_op_loader_duty_phase_clamp.sv
// Limits one transducer's duty to half its period and phase to period-1.
module duty_phase_clamp #(
   parameter int WIDTH = normal_op_loader_pkg::WIDTH
) (
   input  logic [WIDTH-1:0] i_cycle,
   input  logic [WIDTH-1:0] i_duty,
   input  logic [WIDTH-1:0] i_phase,
   output logic [WIDTH-1:0] o_duty,
   output logic [WIDTH-1:0] o_phase
);
   import normal_op_loader_pkg::*;

   logic [WIDTH-1:0] w_half;
   assign w_half = i_cycle >> 1;

   // Zero period is tested first so cycle-1 never wraps.
   always_comb begin
      o_duty  = i_duty;
      o_phase = i_phase;
      if (i_cycle == '0) begin
         o_duty  = '0;
         o_phase = '0;
      end else begin
         if (i_phase >= i_cycle) o_phase = i_cycle - WIDTH'(1);
         if (i_duty > w_half)    o_duty  = w_half;
      end
   end
endmodule

// File: rtl/normal_op_loader.sv
// Sweeps the duty/phase BRAM into shadow registers, clamps each entry, then
// commits the whole array in one cycle so the silent stage never sees a partial update.
module normal_op_loader #(
   parameter int WIDTH  = normal_op_loader_pkg::WIDTH,
   parameter int DEPTH  = normal_op_loader_pkg::TRANS_NUM,
   parameter int RD_LAT = normal_op_loader_pkg::RD_LAT
) (
   input  logic              i_clk,
   input  logic              i_reset,
   normal_op_loader_if.slave bus
);
   import normal_op_loader_pkg::*;

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   state_t                          r_state, w_next;
   logic [ADDR_W-1:0]               r_cnt;
   logic [RD_LAT-1:0]               r_vld_pipe;
   logic [RD_LAT-1:0][ADDR_W-1:0]   r_idx_pipe;
   logic [DEPTH-1:0][WIDTH-1:0]     r_sh_duty, r_sh_phase, r_duty, r_phase;
   logic                            r_out_valid, r_overrun;
   logic                            w_busy, w_cap_vld;
   logic [ADDR_W-1:0]               w_addr, w_cap_idx;
   logic [WIDTH-1:0]                w_cl_duty, w_cl_phase;
   logic                            w_unused;

   assign w_cap_vld = r_vld_pipe[RD_LAT-1];
   assign w_cap_idx = r_idx_pipe[RD_LAT-1];
   assign w_unused  = ^{bus.i_bram_dout[31:16+WIDTH], bus.i_bram_dout[15:WIDTH]};

   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= ST_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      w_busy = 1'b1;
      w_addr = '0;
      case (r_state)
         ST_IDLE: begin
            w_busy = 1'b0;
            if (bus.i_update) w_next = ST_READ;
         end
         ST_READ: begin
            w_addr = r_cnt;
            if (r_cnt == LAST) w_next = ST_DRAIN;
         end
         ST_DRAIN:  if (w_cap_vld && (w_cap_idx == LAST)) w_next = ST_COMMIT;
         ST_COMMIT: w_next = ST_IDLE;
         default:   w_next = ST_IDLE;
      endcase
   end

   // Address and valid travel together so each word lands in its own shadow slot.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_cnt      <= '0;
         r_vld_pipe <= '0;
         r_idx_pipe <= '0;
      end else begin
         r_cnt         <= (r_state == ST_READ && r_cnt != LAST) ? r_cnt + ADDR_W'(1) : '0;
         r_vld_pipe[0] <= (r_state == ST_READ);
         r_idx_pipe[0] <= r_cnt;
         for (int i = 1; i < RD_LAT; i++) begin
            r_vld_pipe[i] <= r_vld_pipe[i-1];
            r_idx_pipe[i] <= r_idx_pipe[i-1];
         end
      end
   end

   duty_phase_clamp #(.WIDTH(WIDTH)) u_clamp (
      .i_cycle (bus.i_cycle[w_cap_idx]),
      .i_duty  (bus.i_bram_dout[WIDTH-1:0]),
      .i_phase (bus.i_bram_dout[16 +: WIDTH]),
      .o_duty  (w_cl_duty),
      .o_phase (w_cl_phase)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_sh_duty   <= '0;
         r_sh_phase  <= '0;
         r_duty      <= '0;
         r_phase     <= '0;
         r_out_valid <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         if (w_cap_vld) begin
            r_sh_duty[w_cap_idx]  <= w_cl_duty;
            r_sh_phase[w_cap_idx] <= w_cl_phase;
         end
         if (r_state == ST_COMMIT) begin
            r_duty  <= r_sh_duty;
            r_phase <= r_sh_phase;
         end
         r_out_valid <= (r_state == ST_COMMIT);
         r_overrun   <= bus.i_update && w_busy;
      end
   end

   assign bus.o_bram_addr = w_addr;
   assign bus.o_duty      = r_duty;
   assign bus.o_phase     = r_phase;
   assign bus.o_busy      = w_busy;
   assign bus.o_out_valid = r_out_valid;
   assign bus.o_overrun   = r_overrun;
endmodule

// File: tb/tb_normal_op_loader.sv
// Scoreboard bench: expected arrays queued at UPDATE, checked when OUT_VALID fires.
module tb_normal_op_loader;
   import normal_op_loader_pkg::*;

   localparam int W = WIDTH;
   localparam int D = TRANS_NUM;
   typedef logic [D-1:0][W-1:0] arr_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   normal_op_loader_if #(.WIDTH(W), .DEPTH(D)) bus ();

   normal_op_loader #(.WIDTH(W), .DEPTH(D), .RD_LAT(RD_LAT)) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   logic [31:0] mem [256];
   logic [31:0] bram_r1;
   arr_t        cyc;
   arr_t        q_duty[$], q_phase[$];
   arr_t        cur_duty, cur_phase;
   int          n_chk = 0, n_pass = 0;

   assign bus.i_cycle = cyc;

   // Two-stage registered BRAM read model.
   always @(posedge clk) begin
      bram_r1         <= mem[bus.o_bram_addr];
      bus.i_bram_dout <= bram_r1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   function automatic void model(output arr_t ed, output arr_t ep);
      for (int k = 0; k < D; k++) begin
         int c, d, p;
         c = int'(cyc[k]);
         d = int'(mem[k][12:0]);
         p = int'(mem[k][28:16]);
         if (c == 0) begin
            d = 0;
            p = 0;
         end else begin
            if (p > c - 1) p = c - 1;
            if (2 * d > c) d = c / 2;
         end
         ed[k] = W'(d);
         ep[k] = W'(p);
      end
   endfunction

   always @(negedge clk) begin
      if (bus.o_out_valid) begin
         if (q_duty.size() == 0) begin
            chk("unexpected_out_valid", 1, 0);
         end else begin
            arr_t ed, ep;
            ed = q_duty.pop_front();
            ep = q_phase.pop_front();
            for (int k = 0; k < D; k++) begin
               chk($sformatf("duty[%0d]", k), 32'(bus.o_duty[k]), 32'(ed[k]));
               chk($sformatf("phase[%0d]", k), 32'(bus.o_phase[k]), 32'(ep[k]));
            end
            cur_duty  = ed;
            cur_phase = ep;
         end
      end
   end

   // Pulses UPDATE, then walks the sweep one negedge at a time; i counts cycles after E0.
   task automatic sweep(input int ovr_a, input int ovr_b, input int rst_at);
      arr_t ed, ep;
      int   lat, nbusy;
      bit   seen;
      lat = 0; nbusy = 0; seen = 1'b0;
      model(ed, ep);
      q_duty.push_back(ed);
      q_phase.push_back(ep);
      bus.i_update = 1'b1;
      @(negedge clk);
      bus.i_update = 1'b0;
      for (int i = 1; i <= 400; i++) begin
         if (i == 1) chk("no_overrun_on_accept", 32'(bus.o_overrun), 0);
         if ((ovr_a > 0 && i == ovr_a + 1) || (ovr_b > 0 && i == ovr_b + 1))
            chk("overrun_pulse", 32'(bus.o_overrun), 1);
         if (i == 1)   chk("addr_k0", 32'(bus.o_bram_addr), 0);
         if (i == 2)   chk("addr_k1", 32'(bus.o_bram_addr), 1);
         if (i == 249) chk("addr_k248", 32'(bus.o_bram_addr), 248);
         if (i == 250) chk("addr_after_read", 32'(bus.o_bram_addr), 0);
         if (i == 100) begin
            chk("hold_duty0", 32'(bus.o_duty[0]), 32'(cur_duty[0]));
            chk("hold_phase_last", 32'(bus.o_phase[D-1]), 32'(cur_phase[D-1]));
         end
         if (bus.o_busy) nbusy++;
         if (bus.o_out_valid) begin
            seen = 1'b1;
            lat  = i - 1;
            chk("busy_after_commit", 32'(bus.o_busy), 0);
            break;
         end
         if (rst_at > 0 && i == rst_at) begin
            rst = 1'b1;
            void'(q_duty.pop_back());
            void'(q_phase.pop_back());
            cur_duty  = '0;
            cur_phase = '0;
         end
         if (rst_at > 0 && i == rst_at + 2) begin
            rst = 1'b0;
            return;
         end
         bus.i_update = (ovr_a > 0 && i == ovr_a) || (ovr_b > 0 && i == ovr_b);
         @(negedge clk);
      end
      bus.i_update = 1'b0;
      chk("out_valid_seen", 32'(seen), 1);
      chk("commit_latency", 32'(lat), 252);
      chk("busy_cycles", 32'(nbusy), 252);
   endtask

   task automatic fill_const();
      for (int k = 0; k < 256; k++) mem[k] = {3'b0, 13'd2500, 3'b0, 13'd1250};
   endtask

   task automatic fill_ramp();
      for (int k = 0; k < 256; k++) mem[k] = {3'b0, 13'(4999 - k), 3'b0, 13'(k)};
   endtask

   initial begin
      cur_duty  = '0;
      cur_phase = '0;
      for (int k = 0; k < D; k++) cyc[k] = 13'd5000;
      fill_const();
      bus.i_update = 1'b1;
      repeat (4) @(negedge clk);
      chk("rst_busy", 32'(bus.o_busy), 0);
      chk("rst_out_valid", 32'(bus.o_out_valid), 0);
      chk("rst_overrun", 32'(bus.o_overrun), 0);
      chk("rst_addr", 32'(bus.o_bram_addr), 0);
      chk("rst_duty0", 32'(bus.o_duty[0]), 0);
      chk("rst_phase_last", 32'(bus.o_phase[D-1]), 0);
      bus.i_update = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("no_sweep_from_reset_update", 32'(bus.o_busy), 0);

      // Uniform word, then a ramp started the cycle right after OUT_VALID.
      sweep(0, 0, 0);
      chk("const_duty", 32'(bus.o_duty[17]), 1250);
      chk("const_phase", 32'(bus.o_phase[D-1]), 2500);
      fill_ramp();
      @(negedge clk);
      sweep(0, 0, 0);
      chk("ramp_duty0", 32'(bus.o_duty[0]), 0);
      chk("ramp_phase1", 32'(bus.o_phase[1]), 4998);
      chk("ramp_duty247", 32'(bus.o_duty[247]), 247);
      chk("ramp_phase248", 32'(bus.o_phase[248]), 4751);

      // Clamp corners plus random words and periods elsewhere.
      cyc[3] = 13'd100;
      cyc[4] = 13'd0;
      mem[3] = {3'b0, 13'd150, 3'b0, 13'd80};
      for (int k = 5; k < D; k++) begin
         mem[k] = $urandom;
         cyc[k] = 13'($urandom_range(1, 8191));
      end
      repeat (3) @(negedge clk);
      sweep(0, 0, 0);
      chk("clamp_duty3", 32'(bus.o_duty[3]), 50);
      chk("clamp_phase3", 32'(bus.o_phase[3]), 99);
      chk("clamp_duty4", 32'(bus.o_duty[4]), 0);
      chk("clamp_phase4", 32'(bus.o_phase[4]), 0);

      // Overrun mid-sweep and on the commit cycle.
      for (int k = 0; k < D; k++) cyc[k] = 13'd5000;
      fill_const();
      repeat (3) @(negedge clk);
      sweep(100, 252, 0);
      repeat (300) @(negedge clk);
      chk("queue_empty_after_overrun", 32'(q_duty.size()), 0);

      // Reset mid-sweep wipes everything and never commits.
      fill_ramp();
      sweep(0, 0, 150);
      chk("abort_busy", 32'(bus.o_busy), 0);
      for (int k = 0; k < D; k += 31) begin
         chk($sformatf("abort_duty[%0d]", k), 32'(bus.o_duty[k]), 0);
         chk($sformatf("abort_phase[%0d]", k), 32'(bus.o_phase[k]), 0);
      end
      repeat (300) @(negedge clk);
      chk("queue_empty_after_abort", 32'(q_duty.size()), 0);
      sweep(0, 0, 0);
      chk("fresh_duty5", 32'(bus.o_duty[5]), 5);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/normal_op_loader.md
NORMAL_OP_LOADER -- requirements
Module: normal_op_loader

Interface
REQ-001 Parameter WIDTH, default 13, bit width of cycle/duty/phase values.
REQ-002 Parameter DEPTH, default 249, number of transducers.
REQ-003 Parameter RD_LAT, default 2, BRAM read latency in clocks.
REQ-004 CLK  in  1  single clock (ultrasound low-speed clock domain); one clock, all logic on rising edge.
REQ-005 RESET  in  1  synchronous, active-high reset.
REQ-006 UPDATE  in  1  one-cycle pulse from the sync stage; starts a sweep.
REQ-007 CYCLE  in  [WIDTH-1:0] x DEPTH  per-transducer period, used for clamping.
REQ-008 BRAM_ADDR  out  8  read address into the CPU-written duty/phase BRAM.
REQ-009 BRAM_DOUT  in  32  read data: [28:16]=phase, [12:0]=duty, other bits ignored.
REQ-010 DUTY  out  [WIDTH-1:0] x DEPTH  committed duty array, feeds the silent stage.
REQ-011 PHASE  out  [WIDTH-1:0] x DEPTH  committed phase array, feeds the silent stage.
REQ-012 BUSY  out  1  high while a sweep is in progress.
REQ-013 OUT_VALID  out  1  one-cycle pulse on the commit cycle.
REQ-014 OVERRUN  out  1  one-cycle pulse when UPDATE arrives while BUSY.

Function
REQ-015 FSM states: IDLE, READ, DRAIN, COMMIT; the encoding is a typedef enum.
REQ-016 IDLE: UPDATE=1 sampled at edge E0 -> READ, address counter=0, BUSY=1 from E0.
REQ-017 READ: BRAM_ADDR=k is driven in the cycle after edge E0+k, k=0..DEPTH-1; last address -> DRAIN.
REQ-018 Data for address k is valid RD_LAT cycles after that address is presented and is captured into shadow entry k via a valid-delay pipeline of length RD_LAT.
REQ-019 DRAIN: wait until the final pipeline valid has been captured, then -> COMMIT.
REQ-020 COMMIT: on edge E0+DEPTH+RD_LAT+1 (252 with defaults), DUTY/PHASE <= shadow arrays together, OUT_VALID=1 for exactly that cycle, BUSY=0 afterwards, -> IDLE.
REQ-021 Outputs change only at COMMIT, never element-by-element.
REQ-022 Clamp applied at capture: phase >= CYCLE[k] -> CYCLE[k]-1; duty > CYCLE[k]>>1 -> CYCLE[k]>>1; CYCLE[k]=0 -> duty=0, phase=0.
REQ-023 The clamp compare is WIDTH-bit unsigned; no wrap-around on CYCLE-1 because the zero case is handled first.
REQ-024 UPDATE while BUSY (including the COMMIT cycle) is ignored and pulses OVERRUN for one cycle; the sweep is unaffected.
REQ-025 UPDATE in the cycle after COMMIT starts a new sweep normally.
REQ-026 BRAM_ADDR holds 0 when not in READ.

Reset
REQ-027 RESET=1 at any edge: state=IDLE, counter=0, pipeline valids=0, BUSY=0, OUT_VALID=0, OVERRUN=0, BRAM_ADDR=0.
REQ-028 Reset clears DUTY, PHASE and shadow arrays to 0.
REQ-029 Reset mid-sweep aborts with no commit; a sweep in progress never produces a partial update.
REQ-030 UPDATE during RESET is ignored; the first sweep requires UPDATE after RESET deasserts.

Structure
REQ-031 WIDTH, TRANS_NUM (249), RD_LAT and the FSM state enum belong in the shared package.
REQ-032 Clamp logic is one sub-module, duty_phase_clamp (pure combinational, one transducer).
REQ-033 Shadow and output arrays are registers; no BRAM inferred inside the block.

Verification
REQ-034 BRAM word k={3'b0,13'd2500,3'b0,13'd1250}, CYCLE=5000 all, UPDATE pulse -> OUT_VALID 252 cycles later, DUTY=1250, PHASE=2500 all, BUSY high 252 cycles.
REQ-035 Word k with duty=k, phase=4999-k, CYCLE=5000 -> DUTY[k]=k, PHASE[k]=4999-k; verifies address/data alignment at indices 0, 1, 247, 248.
REQ-036 Clamp: CYCLE[3]=100, duty=80, phase=150 -> DUTY[3]=50, PHASE[3]=99; CYCLE[4]=0 -> DUTY[4]=0, PHASE[4]=0.
REQ-037 Second UPDATE 100 cycles into a sweep -> OVERRUN pulse at that cycle, single OUT_VALID, outputs from the first sweep only.
REQ-038 RESET asserted 150 cycles into a sweep with prior outputs 1250/2500 -> all outputs 0, no OUT_VALID; a fresh UPDATE then completes normally.
REQ-039 UPDATE on the cycle immediately after OUT_VALID -> new sweep accepted, no OVERRUN.
